execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage RV32I pipeline: applies operand forwarding, runs the ALU, resolves branch/jump
//  and computes the branch target. Registers the EX/MEM pipeline fields consumed directly by the memory stage.
//  PCSrcE/PCTargetE are combinational and feed back to fetch; everything else is registered.
// PARAMETERS
//  DATA_W   32  datapath / PC width
//  RADDR_W  5   register-file index width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-low reset
//  RegWriteE    in   1        ID/EX: rd write enable
//  ResultSrcE   in   1        ID/EX: 0=ALU result, 1=memory data at writeback
//  MemWriteE    in   1        ID/EX: store enable
//  JumpE        in   1        ID/EX: unconditional jump (jal)
//  BranchE      in   1        ID/EX: beq
//  ALUSrcE      in   1        SrcB select: 0=forwarded rs2, 1=ImmExtE
//  ALUControlE  in   3        ALU operation (see BEHAVIOUR)
//  RD1E, RD2E   in   DATA_W   register-file read data rs1/rs2
//  ImmExtE      in   DATA_W   sign-extended immediate
//  RdE          in   RADDR_W  destination register
//  PCE          in   DATA_W   PC of instruction in EX
//  PCPlus4E     in   DATA_W   PC+4 of instruction in EX
//  ForwardAE    in   2        hazard unit select for SrcA
//  ForwardBE    in   2        hazard unit select for rs2 value
//  ResultW      in   DATA_W   writeback result (forwarding source)
//  PCSrcE       out  1        comb: redirect fetch to PCTargetE
//  PCTargetE    out  DATA_W   comb: PCE + ImmExtE
//  RegWriteM, ResultSrcM, MemWriteM  out 1 each   registered controls
//  RDM          out  RADDR_W  registered RdE
//  PCPlus4M     out  DATA_W   registered PCPlus4E
//  WriteDataM   out  DATA_W   registered forwarded rs2 (store data)
//  ALUResultM   out  DATA_W   registered ALU result
// BEHAVIOUR
//  - Forward mux (A on RD1E, B on RD2E): 00=register data, 01=ResultW, 10=ALUResultM (this block's own
//    output register), 11=reserved, treated as 00.
//  - SrcA = fwdA; WriteDataE = fwdB; SrcB = ALUSrcE ? ImmExtE : fwdB.
//  - ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 0/1); others -> 0.
//    Add/sub wrap modulo 2^DATA_W, no overflow flag. ZeroE = (ALUResult == 0).
//  - PCSrcE = JumpE | (BranchE & ZeroE); PCTargetE = PCE + ImmExtE, wraps modulo 2^DATA_W.
//  - EX/MEM register: on each posedge clk with rst high, all M outputs capture their E-stage values;
//    latency exactly 1 cycle, no stall or enable (flushes arrive as zeroed controls from ID/EX).
//  - rst low: all registered outputs go to 0 immediately (async), held while low; first capture on the
//    first posedge after rst deasserts. PCSrcE/PCTargetE stay combinational of inputs during reset.
//  - ForwardAE=10 during/just after reset forwards ALUResultM=0.
//  - Back-to-back dependency: ALUResultM used via forwarding is the value registered on the previous edge.
// TESTING
//  1 Reset: drive rst=0 mid-run with nonzero M outputs -> all M outputs 0 before next clk edge.
//  2 add: RD1E=5, ImmExtE=7, ALUSrcE=1, ALUControlE=000, RdE=3, RegWriteE=1 -> next edge ALUResultM=12,
//    RDM=3, RegWriteM=1.
//  3 Forwarding: cycle N ALUResultM=12; ForwardAE=10, RD2E=2, ALUControlE=001 -> ALUResultM=10;
//    ForwardBE=01, ResultW=0xFFFF_FFFF, MemWriteE=1, ALUSrcE=1 -> WriteDataM=0xFFFF_FFFF.
//  4 beq: SrcA=SrcB=9, BranchE=1, PCE=0x100, ImmExtE=0xFFFF_FFF0 -> PCSrcE=1 same cycle, PCTargetE=0xF0;
//    SrcA=9, SrcB=8 -> PCSrcE=0. JumpE=1 any operands -> PCSrcE=1.
//  5 slt/wrap: SrcA=0x8000_0000, SrcB=1, slt -> 1; SrcA=0xFFFF_FFFF, SrcB=1, add -> 0.
//  6 Reserved codes: ForwardAE=11 -> RD1E used; ALUControlE=111 -> ALUResultM=0.

Source files
------------

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, grouped as one bundle.
// The master side is the upstream pipeline (or a bench); the slave side is the stage itself.
interface execute_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
);

  // ID/EX controls
  logic               RegWriteE;
  logic               ResultSrcE;
  logic               MemWriteE;
  logic               JumpE;
  logic               BranchE;
  logic               ALUSrcE;
  logic [2:0]         ALUControlE;

  // ID/EX data
  logic [DATA_W-1:0]  RD1E;
  logic [DATA_W-1:0]  RD2E;
  logic [DATA_W-1:0]  ImmExtE;
  logic [RADDR_W-1:0] RdE;
  logic [DATA_W-1:0]  PCE;
  logic [DATA_W-1:0]  PCPlus4E;

  // Hazard unit forwarding selects and writeback forwarding source
  logic [1:0]         ForwardAE;
  logic [1:0]         ForwardBE;
  logic [DATA_W-1:0]  ResultW;

  // Combinational redirect back to fetch
  logic               PCSrcE;
  logic [DATA_W-1:0]  PCTargetE;

  // EX/MEM registered fields
  logic               RegWriteM;
  logic               ResultSrcM;
  logic               MemWriteM;
  logic [RADDR_W-1:0] RDM;
  logic [DATA_W-1:0]  PCPlus4M;
  logic [DATA_W-1:0]  WriteDataM;
  logic [DATA_W-1:0]  ALUResultM;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
    output ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
    input  RegWriteM, ResultSrcM, MemWriteM, RDM, PCPlus4M, WriteDataM, ALUResultM
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
    input  ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
    output RegWriteM, ResultSrcM, MemWriteM, RDM, PCPlus4M, WriteDataM, ALUResultM
  );

endinterface

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump resolution and
// branch target. The redirect (PCSrcE/PCTargetE) is combinational; EX/MEM fields are registered.
module execute_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  execute_stage_if.slave bus
);

  typedef enum logic [1:0] {
    FwdReg    = 2'b00,
    FwdResW   = 2'b01,
    FwdAluM   = 2'b10,
    FwdRsvd   = 2'b11
  } fwd_sel_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_op_e;

  logic [DATA_W-1:0]  src_a;
  logic [DATA_W-1:0]  fwd_b;
  logic [DATA_W-1:0]  src_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;

  logic               reg_write_q;
  logic               result_src_q;
  logic               mem_write_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]  pc_plus4_q;
  logic [DATA_W-1:0]  write_data_q;
  logic [DATA_W-1:0]  alu_result_q;

  // Forwarding muxes; the reserved select falls back to register data.
  always_comb begin
    src_a = bus.RD1E;
    fwd_b = bus.RD2E;
    case (fwd_sel_e'(bus.ForwardAE))
      FwdResW: src_a = bus.ResultW;
      FwdAluM: src_a = alu_result_q;
      default: src_a = bus.RD1E;
    endcase
    case (fwd_sel_e'(bus.ForwardBE))
      FwdResW: fwd_b = bus.ResultW;
      FwdAluM: fwd_b = alu_result_q;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

  // ALU; add/sub wrap naturally, undefined opcodes yield zero.
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(bus.ALUControlE))
      AluAdd:  alu_result = src_a + src_b;
      AluSub:  alu_result = src_a - src_b;
      AluAnd:  alu_result = src_a & src_b;
      AluOr:   alu_result = src_a | src_b;
      AluSlt:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign alu_zero      = (alu_result == '0);
  assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & alu_zero);
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

  // EX/MEM pipeline register: no enable, flushes arrive as zeroed controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      write_data_q <= '0;
      alu_result_q <= '0;
    end else begin
      reg_write_q  <= bus.RegWriteE;
      result_src_q <= bus.ResultSrcE;
      mem_write_q  <= bus.MemWriteE;
      rd_q         <= bus.RdE;
      pc_plus4_q   <= bus.PCPlus4E;
      write_data_q <= fwd_b;
      alu_result_q <= alu_result;
    end
  end

  assign bus.RegWriteM  = reg_write_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.RDM        = rd_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.ALUResultM = alu_result_q;

endmodule
